// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier arbiter slice.
package mul_arb_pkg;

  localparam int unsigned MUL_W  = 64;
  localparam int unsigned PROD_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_64b.sv
// Combinational 64x64 -> 128-bit unsigned multiplier.
module mul_64b (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] prod
);

  assign prod = {64'd0, a} * {64'd0, b};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, cyclically.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx
);

  int unsigned base;
  logic        found;

  // Two passes (ptr..NREQ-1, then 0..ptr-1) give the cyclic search order.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    base    = (32'(ptr) >= NREQ) ? 32'd0 : 32'(ptr);
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && (i >= base) && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && (i < base) && req[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/mul_64b_arbiter.sv
// Shares one combinational mul_64b between NREQ valid/ready requesters as a multicycle path.
module mul_64b_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned MUL_CYCLES = 1,
  parameter int unsigned ID_W       = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*MUL_W-1:0]  req_a,
  input  logic [NREQ*MUL_W-1:0]  req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [PROD_W-1:0]      rsp_prod,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

  state_t              state, state_nx;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [MUL_W-1:0]    op_a, op_b;
  logic [ID_W-1:0]     id_q;
  logic [NREQ-1:0]     gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic [MUL_W-1:0]    a_sel, b_sel;
  logic [PROD_W-1:0]   mul_out;
  logic                accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  mul_64b u_mul (
    .a    (op_a),
    .b    (op_b),
    .prod (mul_out)
  );

  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign accept    = (state == IDLE) && (|req_valid);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand mux driven by the one-hot grant, independent of the data itself.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*MUL_W +: MUL_W];
        b_sel = req_b[i*MUL_W +: MUL_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)        state_nx = EXEC;
      EXEC:    if (cnt == '0)     state_nx = DONE;
      DONE:    if (rsp_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Operand capture, settle counter, round-robin pointer and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      id_q     <= '0;
      rsp_prod <= '0;
      rsp_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= a_sel;
            op_b   <= b_sel;
            id_q   <= gnt_idx;
            rr_ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            cnt    <= CNT_W'(MUL_CYCLES - 1);
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_prod <= mul_out;
            rsp_id   <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
